// File: rtl/puf_crp_controller.sv
// rtl/puf_crp_controller.sv - PUF challenge/response initiator with majority vote and instability mask
module puf_crp_controller #(
    parameter int unsigned SETTLE = 8,
    parameter int unsigned NVOTE  = 5,
    parameter logic [31:0] SEED   = 32'h1ACE_B00C
) (
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic        use_lfsr_i,
    input  logic [31:0] chal_in_i,
    output logic        busy_o,
    output logic        puf_clear_o,
    output logic        puf_clr_o,
    output logic [31:0] puf_c_o,
    input  logic [31:0] puf_o_i,
    output logic [31:0] resp_o,
    output logic [31:0] unstable_o,
    output logic [31:0] chal_out_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRST,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         vote_q, vote_d;
    logic [31:0]        chal_q, chal_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [31:0][3:0]   ones_q, ones_d;
    logic [31:0]        resp_q, resp_d;
    logic [31:0]        unst_q, unst_d;
    logic [31:0]        cout_q, cout_d;
    logic [31:0]        lfsr_next;

    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vote_d  = vote_q;
        chal_d  = chal_q;
        lfsr_d  = lfsr_q;
        ones_d  = ones_q;
        resp_d  = resp_q;
        unst_d  = unst_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    chal_d  = use_lfsr_i ? lfsr_q : chal_in_i;
                    if (use_lfsr_i) begin
                        lfsr_d = lfsr_next;
                    end
                    ones_d  = '0;
                    vote_d  = '0;
                    cnt_d   = '0;
                    state_d = S_PRST;
                end
            end
            S_PRST: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                for (int i = 0; i < 32; i++) begin
                    ones_d[i] = ones_q[i] + 4'(puf_o_i[i]);
                end
                vote_d = vote_q + 4'd1;
                if (vote_q == 4'(NVOTE - 1)) begin
                    // Result registers load together with the final count so DONE presents it at once.
                    for (int i = 0; i < 32; i++) begin
                        resp_d[i] = ones_d[i] > 4'(NVOTE / 2);
                        unst_d[i] = (ones_d[i] != 4'd0) && (ones_d[i] != 4'(NVOTE));
                    end
                    cout_d  = chal_q;
                    state_d = S_DONE;
                end else begin
                    state_d = S_PRST;
                end
            end
            S_DONE: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vote_q  <= '0;
            chal_q  <= '0;
            lfsr_q  <= LFSR_INIT;
            ones_q  <= '0;
            resp_q  <= '0;
            unst_q  <= '0;
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vote_q  <= vote_d;
            chal_q  <= chal_d;
            lfsr_q  <= lfsr_d;
            ones_q  <= ones_d;
            resp_q  <= resp_d;
            unst_q  <= unst_d;
            cout_q  <= cout_d;
        end
    end

    // The array is only released from reset while a challenge is settling or being sampled.
    assign puf_clear_o  = !((state_q == S_SETTLE) || (state_q == S_SAMPLE));
    assign puf_clr_o    = puf_clear_o;
    assign puf_c_o      = chal_q;
    assign busy_o       = (state_q != S_IDLE);
    assign resp_valid_o = (state_q == S_DONE);
    assign resp_o       = resp_q;
    assign unstable_o   = unst_q;
    assign chal_out_o   = cout_q;

endmodule
